// File: rtl/regfile_2w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2w
// Purpose  : 2**AW x DW register file with two write ports, two combinational
//            read ports and a per-entry busy scoreboard (set by bset, cleared
//            by any accepted write, set wins when both target one entry).
// Revision : 1.0 - initial release
//
// Parameters:
//   DW       data width in bits
//   AW       address width (depth = 2**AW)
//   ZERO_REG 1 = entry 0 reads as zero and ignores writes/bset
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   we0/wa0/wd0      write port 0 (enable / address / data)
//   we1/wa1/wd1      write port 1; wins over port 0 on an address collision
//   ra1/ra2          read addresses
//   rd1/rd2          read data
//   bset/bwa         scoreboard set request / address
//   rbusy1/rbusy2    busy flag of entry ra1 / ra2
//
// Optional feature:
//   REGFILE_2W_BYPASS_EN  same-cycle write-to-read forwarding on both read
//                         ports (port 1 over port 0); a forwarded entry
//                         reports rbusy = 0.
// ============================================================================
module regfile_2w #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          bset,
  input  logic [AW-1:0] bwa,
  output logic          rbusy1,
  output logic          rbusy2
);

  localparam int C_DEPTH = 2**AW;

  logic [DW-1:0]      mem_q [C_DEPTH];
  logic [DW-1:0]      mem_d [C_DEPTH];
  logic [C_DEPTH-1:0] busy_q;
  logic [C_DEPTH-1:0] busy_d;

  logic w_we0_ok;
  logic w_we1_ok;
  logic w_bset_ok;

  function automatic logic is_zero_addr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Requests to a hardwired-zero entry are dropped here, so the storage and
  // forwarding logic below never needs to special-case address 0 for writes.
  assign w_we0_ok  = we0  && !is_zero_addr(wa0);
  assign w_we1_ok  = we1  && !is_zero_addr(wa1);
  assign w_bset_ok = bset && !is_zero_addr(bwa);

  // Next state. Assignment order encodes priority: port 1 data overrides
  // port 0 on a collision, and a bset overrides the busy-clear of a write.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (w_we0_ok) begin
      mem_d[wa0]  = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (w_we1_ok) begin
      mem_d[wa1]  = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (w_bset_ok) begin
      busy_d[bwa] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [DW-1:0] read_data(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = mem_q[ra];
`ifdef REGFILE_2W_BYPASS_EN
    if (w_we0_ok && (wa0 == ra)) v = wd0;
    if (w_we1_ok && (wa1 == ra)) v = wd1;
`endif
    if (is_zero_addr(ra)) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] ra);
    logic b;
    b = busy_q[ra];
`ifdef REGFILE_2W_BYPASS_EN
    // Data is being delivered this cycle, so the entry is no longer waiting.
    if ((w_we0_ok && (wa0 == ra)) || (w_we1_ok && (wa1 == ra))) b = 1'b0;
`endif
    if (is_zero_addr(ra)) b = 1'b0;
    return b;
  endfunction

  // Outputs are forced to zero during reset so forwarded write data cannot
  // leak out while the array is held cleared.
  always_comb begin
    rd1    = '0;
    rd2    = '0;
    rbusy1 = 1'b0;
    rbusy2 = 1'b0;
    if (!rst) begin
      rd1    = read_data(ra1);
      rd2    = read_data(ra2);
      rbusy1 = read_busy(ra1);
      rbusy2 = read_busy(ra2);
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_2w.md
REGFILE_2W -- requirements
Module: regfile_2w

Interface
- REQ-001: Parameter DW, default 32, data width in bits.
- REQ-002: Parameter AW, default 5, address width; depth = 2**AW entries.
- REQ-003: Parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero, 0 = entry 0 is an ordinary register.
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: we0  input  1  write enable, port 0.
- REQ-007: wa0  input  AW  write address, port 0.
- REQ-008: wd0  input  DW  write data, port 0.
- REQ-009: we1  input  1  write enable, port 1.
- REQ-010: wa1  input  AW  write address, port 1.
- REQ-011: wd1  input  DW  write data, port 1.
- REQ-012: ra1  input  AW  read address, port 1.
- REQ-013: ra2  input  AW  read address, port 2.
- REQ-014: rd1  output  DW  read data, port 1.
- REQ-015: rd2  output  DW  read data, port 2.
- REQ-016: bset  input  1  scoreboard set request; marks entry bwa pending.
- REQ-017: bwa  input  AW  scoreboard set address.
- REQ-018: rbusy1  output  1  pending flag of entry ra1.
- REQ-019: rbusy2  output  1  pending flag of entry ra2.

Function
- REQ-020: Storage is 2**AW x DW; each port writes wd to wa on the rising edge when its we=1.
- REQ-021: Both ports write the same address in the same cycle: port 1 data is stored; port 0 data is discarded.
- REQ-022: ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return 0; rbusy for address 0 is always 0; bset to address 0 is ignored.
- REQ-023: Reads are combinational; rd1/rd2 reflect the stored entry with zero added latency.
- REQ-024: Scoreboard holds one busy bit per entry; bset=1 sets busy[bwa] on the rising edge.
- REQ-025: Any accepted write (we0 or we1) to an address clears its busy bit on the same edge.
- REQ-026: bset and a write to the same address in the same cycle: busy is set (a new producer overrides retirement); the data is still written.
- REQ-027: Two writes and a bset to three distinct addresses in one cycle all take effect independently.
- REQ-028: Writing an entry whose busy bit is 0 is legal and leaves the bit at 0.

Reset
- REQ-029: rst=1 asynchronously clears every storage entry to 0 and every busy bit to 0, regardless of clk.
- REQ-030: While rst=1, writes and bset are ignored; rd1/rd2 read 0 and rbusy1/rbusy2 read 0.
- REQ-031: rst asserted mid-cycle with writes pending: no write is committed; the first edge after deassertion operates normally.

Configuration
- REQ-032: Macro REGFILE_2W_BYPASS_EN compiles in same-cycle write-to-read forwarding.
- REQ-033: With REGFILE_2W_BYPASS_EN: if ra matches an enabled write address (respecting ZERO_REG), rd returns that write's data (port 1 over port 0) and rbusy returns 0 in the same cycle.
- REQ-034: Without REGFILE_2W_BYPASS_EN: rd and rbusy reflect stored state only; written data is visible from the cycle after the edge.

Verification
- REQ-035: Reset, then write 0xDEADBEEF to entry 5 via port 0; next cycle ra1=5 -> rd1=0xDEADBEEF.
- REQ-036: ZERO_REG=1, we1 writes 0x1234 to entry 0 and bset with bwa=0 -> rd1=0 and rbusy1=0 afterwards.
- REQ-037: Same cycle: port 0 writes 0xAAAA and port 1 writes 0x5555 to entry 7 -> entry 7 reads 0x5555.
- REQ-038: bset with bwa=3 -> rbusy(3)=1; later write 0x77 to entry 3 -> rbusy(3)=0; bset and write to entry 3 in the same cycle -> rbusy(3)=1 and rd=0x77.
- REQ-039: With BYPASS_EN, we0 writes 0x99 to entry 9 with ra2=9 in the same cycle -> rd2=0x99 before the edge; without BYPASS_EN -> rd2 shows the old value until after the edge.
- REQ-040: Entries 1..31 loaded and busy bits set; rst pulsed between clock edges -> all reads 0 and all rbusy 0 immediately.
